// File: rtl/pb_pkg.sv
// Shared types and constants for the push-button group controller.
package pb_pkg;

   localparam int unsigned N_BTN = 4;

   typedef enum logic [1:0] {
      STABLE_LO,
      WAIT_HI,
      STABLE_HI,
      WAIT_LO
   } db_state_t;

   typedef enum logic {
      MODE_HOLD,
      MODE_TOGGLE
   } pb_mode_t;

   // Debounce counter width; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned cycles);
      return (cycles > 2) ? $clog2(cycles) : 1;
   endfunction

endpackage

// File: rtl/debounce_cell.sv
// One button channel: two-flop synchronizer followed by a counting debounce FSM that
// emits a registered level and a one-cycle pulse on each accepted rise.
module debounce_cell
   import pb_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_btn,
   output logic o_level,
   output logic o_press,
   output logic o_level_nxt,
   output logic o_press_nxt
);

   localparam int unsigned   CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   if (DEBOUNCE_CYCLES < 2) begin : g_bad_param
      $error("debounce_cell: DEBOUNCE_CYCLES must be at least 2");
   end

   logic          r_sync1;
   logic          r_sync2;
   db_state_t     r_state;
   db_state_t     w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic          r_level;
   logic          w_level_nxt;
   logic          r_press;
   logic          w_press_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= STABLE_LO;
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_press <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_level <= w_level_nxt;
         r_press <= w_press_nxt;
      end
   end

   // The first differing sample already counts as one, so acceptance happens on the
   // DEBOUNCE_CYCLES-th consecutive sample.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_level_nxt = r_level;
      w_press_nxt = 1'b0;
      unique case (r_state)
         STABLE_LO: begin
            w_cnt_nxt = '0;
            if (r_sync2) begin
               w_state_nxt = WAIT_HI;
               w_cnt_nxt   = CNT_ONE;
            end
         end
         WAIT_HI: begin
            if (!r_sync2) begin
               w_state_nxt = STABLE_LO;
               w_cnt_nxt   = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = STABLE_HI;
               w_cnt_nxt   = '0;
               w_level_nxt = 1'b1;
               w_press_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CNT_ONE;
            end
         end
         STABLE_HI: begin
            w_cnt_nxt = '0;
            if (!r_sync2) begin
               w_state_nxt = WAIT_LO;
               w_cnt_nxt   = CNT_ONE;
            end
         end
         WAIT_LO: begin
            if (r_sync2) begin
               w_state_nxt = STABLE_HI;
               w_cnt_nxt   = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = STABLE_LO;
               w_cnt_nxt   = '0;
               w_level_nxt = 1'b0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_ONE;
            end
         end
         default: begin
            w_state_nxt = STABLE_LO;
            w_cnt_nxt   = '0;
            w_level_nxt = 1'b0;
         end
      endcase
   end

   assign o_level     = r_level;
   assign o_press     = r_press;
   assign o_level_nxt = w_level_nxt;
   assign o_press_nxt = w_press_nxt;

endmodule

// File: rtl/pb_group_ctrl.sv
// Debounces four push buttons and turns them into per-group LED blanking flags, either
// following the held button (HOLD) or flipping on each press (TOGGLE).
module pb_group_ctrl
   import pb_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] btn_i,
   input  logic             mode_i,
   output logic [N_BTN-1:0] btn_level_o,
   output logic [N_BTN-1:0] btn_press_o,
   output logic [N_BTN-1:0] group_off_o
);

   logic             r_mode_s1;
   logic             r_mode_s2;
   pb_mode_t         w_mode;
   logic [N_BTN-1:0] w_level;
   logic [N_BTN-1:0] w_press;
   logic [N_BTN-1:0] w_level_nxt;
   logic [N_BTN-1:0] w_press_nxt;
   logic [N_BTN-1:0] r_off;
   logic [N_BTN-1:0] w_off_nxt;

   for (genvar g = 0; g < N_BTN; g++) begin : g_btn
      debounce_cell #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_cell (
         .clk        (clk),
         .rst_n      (rst_n),
         .i_btn      (btn_i[g]),
         .o_level    (w_level[g]),
         .o_press    (w_press[g]),
         .o_level_nxt(w_level_nxt[g]),
         .o_press_nxt(w_press_nxt[g])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode_s1 <= 1'b0;
         r_mode_s2 <= 1'b0;
      end else begin
         r_mode_s1 <= mode_i;
         r_mode_s2 <= r_mode_s1;
      end
   end

   assign w_mode = pb_mode_t'(r_mode_s2);

   // On the edge where the synchronized mode changes, hold; the new mode rules apply
   // from the following edge.
   always_comb begin
      w_off_nxt = r_off;
      if (r_mode_s1 == r_mode_s2) begin
         if (w_mode == MODE_HOLD) begin
            w_off_nxt = w_level_nxt;
         end else begin
            w_off_nxt = r_off ^ w_press_nxt;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_off <= '0;
      end else begin
         r_off <= w_off_nxt;
      end
   end

   assign btn_level_o = w_level;
   assign btn_press_o = w_press;
   assign group_off_o = r_off;

endmodule

// File: tb/tb_pb_group_ctrl.sv
// Bench for pb_group_ctrl: directed scenarios plus random button/mode/reset traffic,
// all compared every cycle against a run-length reference model.
module tb_pb_group_ctrl;
   import pb_pkg::*;

   localparam int unsigned D = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] btn_i = 4'h0;
   logic       mode_i = 1'b0;
   logic [3:0] btn_level_o;
   logic [3:0] btn_press_o;
   logic [3:0] group_off_o;

   int unsigned n_checks = 0;
   int unsigned n_fail = 0;

   // Reference model: a button is accepted once D consecutive synchronized samples
   // disagree with the current level.
   logic [3:0] m_s1, m_s2, m_lvl, m_prs, m_off;
   logic       m_m1, m_m2;
   int         m_run[4];

   always #5 clk = ~clk;

   pb_group_ctrl #(
      .DEBOUNCE_CYCLES(D)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_i      (btn_i),
      .mode_i     (mode_i),
      .btn_level_o(btn_level_o),
      .btn_press_o(btn_press_o),
      .group_off_o(group_off_o)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_prs = '0; m_off = '0;
      m_m1 = 1'b0; m_m2 = 1'b0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
   endtask

   task automatic model_edge();
      logic [3:0] lvl_n;
      logic [3:0] prs_n;
      lvl_n = m_lvl;
      prs_n = '0;
      for (int i = 0; i < 4; i++) begin
         if (m_s2[i] != m_lvl[i]) begin
            m_run[i]++;
            if (m_run[i] == int'(D)) begin
               lvl_n[i]  = m_s2[i];
               prs_n[i]  = m_s2[i];
               m_run[i]  = 0;
            end
         end else begin
            m_run[i] = 0;
         end
      end
      if (m_m1 == m_m2) m_off = m_m2 ? (m_off ^ prs_n) : lvl_n;
      m_m2 = m_m1;   m_m1 = mode_i;
      m_s2 = m_s1;   m_s1 = btn_i;
      m_lvl = lvl_n; m_prs = prs_n;
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_edge();
      else model_reset();
      #1;
      check_eq("level", 32'(btn_level_o), 32'(m_lvl));
      check_eq("press", 32'(btn_press_o), 32'(m_prs));
      check_eq("group_off", 32'(group_off_o), 32'(m_off));
   endtask

   task automatic settle();
      btn_i = 4'h0;
      repeat (12) tick();
   endtask

   int first_e;
   int pulses;
   int rise_e;
   int fall_e;
   int hold[4];

   initial begin
      model_reset();

      // Reset with all buttons held, then release.
      btn_i = 4'hF;
      repeat (3) tick();
      check_eq("rst_outputs", 32'({btn_level_o, btn_press_o, group_off_o}), 32'h0);
      rst_n = 1'b1;
      for (int e = 1; e <= 11; e++) begin
         tick();
         if (e == 9)  check_eq("rst_rel_pre_lvl", 32'(btn_level_o), 32'h0);
         if (e == 10) begin
            check_eq("rst_rel_lvl", 32'(btn_level_o), 32'hF);
            check_eq("rst_rel_press", 32'(btn_press_o), 32'hF);
            check_eq("rst_rel_off", 32'(group_off_o), 32'hF);
         end
         if (e == 11) check_eq("rst_rel_no_2nd_press", 32'(btn_press_o), 32'h0);
      end
      settle();

      // Bounce on button 0: high 5, low 3, then held high.
      btn_i[0] = 1'b1; repeat (5) tick();
      btn_i[0] = 1'b0; repeat (3) tick();
      btn_i[0] = 1'b1;
      first_e = -1; pulses = 0;
      for (int e = 1; e <= 14; e++) begin
         tick();
         if (btn_press_o[0]) begin
            pulses++;
            if (first_e < 0) first_e = e;
         end
      end
      check_eq("bounce_press_edge", 32'(first_e), 32'd10);
      check_eq("bounce_pulses", 32'(pulses), 32'd1);
      settle();

      // TOGGLE: two press/release pairs on button 2.
      mode_i = 1'b1;
      repeat (3) tick();
      btn_i[2] = 1'b1; repeat (12) tick();
      check_eq("tgl_press1", 32'(group_off_o[2]), 32'd1);
      btn_i[2] = 1'b0; repeat (12) tick();
      check_eq("tgl_release1", 32'(group_off_o[2]), 32'd1);
      btn_i[2] = 1'b1; repeat (12) tick();
      check_eq("tgl_press2", 32'(group_off_o[2]), 32'd0);
      btn_i[2] = 1'b0; repeat (12) tick();
      check_eq("tgl_release2", 32'(group_off_o[2]), 32'd0);

      // TOGGLE -> HOLD with group 1 blanked and button 1 released.
      btn_i[1] = 1'b1; repeat (12) tick();
      btn_i[1] = 1'b0; repeat (12) tick();
      check_eq("msw_before", 32'(group_off_o), 32'h2);
      mode_i = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         tick();
         if (e == 2) check_eq("msw_edge2", 32'(group_off_o), 32'h2);
         if (e == 3) check_eq("msw_edge3", 32'(group_off_o), 32'h0);
      end

      // HOLD: button 3 held for 20 cycles.
      rise_e = -1; fall_e = -1;
      btn_i[3] = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         tick();
         if (group_off_o[3] && rise_e < 0) rise_e = e;
      end
      btn_i[3] = 1'b0;
      for (int e = 1; e <= 14; e++) begin
         tick();
         if (!group_off_o[3] && fall_e < 0) fall_e = e;
      end
      check_eq("hold_rise_edge", 32'(rise_e), 32'd10);
      check_eq("hold_fall_edge", 32'(fall_e), 32'd10);

      // Reset while button 2 is mid-count (counter = 5).
      btn_i[2] = 1'b1;
      repeat (7) tick();
      rst_n = 1'b0;
      model_reset();
      #1;
      check_eq("midrst_async", 32'({btn_level_o, btn_press_o, group_off_o}), 32'h0);
      repeat (3) tick();
      rst_n = 1'b1;
      first_e = -1;
      for (int e = 1; e <= 12; e++) begin
         tick();
         if (btn_press_o[2] && first_e < 0) first_e = e;
      end
      check_eq("midrst_restart_edge", 32'(first_e), 32'd10);
      settle();

      // Random traffic on all buttons, occasional mode flips and resets.
      for (int i = 0; i < 4; i++) hold[i] = 0;
      repeat (3000) begin
         for (int i = 0; i < 4; i++) begin
            if (hold[i] == 0) begin
               btn_i[i] = ~btn_i[i];
               hold[i]  = int'($urandom_range(1, 14));
            end else begin
               hold[i]--;
            end
         end
         if ($urandom_range(0, 79) == 0) mode_i = ~mode_i;
         if (!rst_n) begin
            rst_n = 1'b1;
         end else if ($urandom_range(0, 499) == 0) begin
            rst_n = 1'b0;
            model_reset();
         end
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
